count_seq_monitor: RTL and testbench



---
 rtl/counter_pkg.sv | 24 ++
 rtl/sat_counter.sv | 32 +++
 rtl/count_seq_monitor.sv | 133 +++++++++++++
 tb/tb_count_seq_monitor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared definitions for the counters library: monitor FSM
//                state encoding and the saturating-increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Monitor FSM state encoding (also exported on state_o for debug)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  // Increment value, holding at the all-ones value of a 'width'-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? max_v : (value + 32'd1);
  endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up-counter that sticks at all ones; sat flags the
//                saturated value.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
  import counter_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         sat
);

  // Counter register: clears on reset, saturating step on inc
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (inc) begin
      value <= W'(sat_inc(32'(value), W));
    end
  end

  assign sat = &value;

endmodule : sat_counter
`default_nettype wire

// File: rtl/count_seq_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_monitor
//  Description : Checks that a sampled count advances by +1 (mod 2^CNT_W),
//                pulses wrap_tick on each accepted MAX->0 step, and keeps
//                saturating wrap / error counts plus a sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_seq_monitor
  import counter_pkg::*;
#(
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned WRAP_W     = 8,
  parameter int unsigned ERR_W      = 4,
  parameter bit          ALLOW_HOLD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CNT_W-1:0]  q_in,
  input  logic              clear_err,
  output logic              wrap_tick,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              wrap_sat,
  output logic              seq_err,
  output logic [ERR_W-1:0]  err_count,
  output logic [1:0]        state_o
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] prev;
  logic [CNT_W-1:0] prev_nxt;
  logic [CNT_W-1:0] exp_val;
  logic             match_inc;
  logic             match_hold;
  logic             prev_is_max;
  logic             wrap_inc;
  logic             err_inc;
  logic             seq_err_nxt;
  logic             err_sat;

  // Expected next sample; the +1 wraps naturally in CNT_W bits
  assign exp_val     = prev + CNT_W'(1);
  assign match_inc   = (q_in == exp_val);
  assign match_hold  = ALLOW_HOLD && (q_in == prev);
  assign prev_is_max = &prev;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clear_err overrides any sample in the same cycle
  always_comb begin
    state_nxt = state;
    if (clear_err) begin
      state_nxt = ST_IDLE;
    end else if (en) begin
      case (state)
        ST_IDLE:  state_nxt = ST_TRACK;
        ST_TRACK: if (!match_inc && !match_hold) state_nxt = ST_ERR;
        ST_ERR:   state_nxt = ST_ERR;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Per-sample decisions: prev update, wrap/error strobes, sticky flag
  always_comb begin
    prev_nxt    = prev;
    wrap_inc    = 1'b0;
    err_inc     = 1'b0;
    seq_err_nxt = seq_err;
    if (clear_err) begin
      seq_err_nxt = 1'b0;
    end else if (en) begin
      case (state)
        ST_IDLE: prev_nxt = q_in;
        ST_TRACK: begin
          if (match_inc) begin
            prev_nxt = q_in;
            wrap_inc = prev_is_max;
          end else if (!match_hold) begin
            prev_nxt    = q_in;
            seq_err_nxt = 1'b1;
            err_inc     = 1'b1;
          end
        end
        ST_ERR:  prev_nxt = q_in;
        default: prev_nxt = prev;
      endcase
    end
  end

  // Registered datapath state and the one-cycle wrap pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= '0;
      wrap_tick <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      prev      <= prev_nxt;
      wrap_tick <= wrap_inc;
      seq_err   <= seq_err_nxt;
    end
  end

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_inc),
    .value (wrap_count),
    .sat   (wrap_sat)
  );

  // Error strobe is dropped once the count is pinned at all ones
  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc && !err_sat),
    .value (err_count),
    .sat   (err_sat)
  );

  assign state_o = state;

endmodule : count_seq_monitor
`default_nettype wire

// File: tb/tb_count_seq_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_seq_monitor
//  Description : Directed self-checking bench. Three monitors share one
//                stimulus stream: A = defaults, B = ALLOW_HOLD=1,
//                C = WRAP_W=2 / ERR_W=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] q_in = 3'd0;
  logic       clear_err = 1'b0;

  logic       a_tick, a_ws, a_se;
  logic [7:0] a_wc;
  logic [3:0] a_ec;
  logic [1:0] a_st;
  logic       b_tick, b_ws, b_se;
  logic [7:0] b_wc;
  logic [3:0] b_ec;
  logic [1:0] b_st;
  logic       c_tick, c_ws, c_se;
  logic [1:0] c_wc;
  logic [1:0] c_ec;
  logic [1:0] c_st;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  count_seq_monitor u_a (
    .clk(clk), .reset(reset), .en(en), .q_in(q_in), .clear_err(clear_err),
    .wrap_tick(a_tick), .wrap_count(a_wc), .wrap_sat(a_ws),
    .seq_err(a_se), .err_count(a_ec), .state_o(a_st)
  );

  count_seq_monitor #(.ALLOW_HOLD(1'b1)) u_b (
    .clk(clk), .reset(reset), .en(en), .q_in(q_in), .clear_err(clear_err),
    .wrap_tick(b_tick), .wrap_count(b_wc), .wrap_sat(b_ws),
    .seq_err(b_se), .err_count(b_ec), .state_o(b_st)
  );

  count_seq_monitor #(.WRAP_W(2), .ERR_W(2)) u_c (
    .clk(clk), .reset(reset), .en(en), .q_in(q_in), .clear_err(clear_err),
    .wrap_tick(c_tick), .wrap_count(c_wc), .wrap_sat(c_ws),
    .seq_err(c_se), .err_count(c_ec), .state_o(c_st)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit later
  task automatic cyc(input logic e, input logic [2:0] q, input logic c);
    en = e; q_in = q; clear_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; en = 1'b0; clear_err = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset(2);
    check("rst_tick", a_tick, 0);
    check("rst_wc",   a_wc,   0);
    check("rst_ws",   a_ws,   0);
    check("rst_se",   a_se,   0);
    check("rst_ec",   a_ec,   0);
    check("rst_st",   a_st,   0);

    // ---------------- wrap 0..7,0,1 ----------------
    cyc(1, 3'd0, 0);
    check("wrap_first_st", a_st, 1);
    check("wrap_first_tick", a_tick, 0);
    for (int v = 1; v <= 7; v++) begin
      cyc(1, 3'(v), 0);
      check("wrap_no_tick", a_tick, 0);
    end
    cyc(1, 3'd0, 0);
    check("wrap_tick", a_tick, 1);
    check("wrap_wc", a_wc, 1);
    check("wrap_c_wc", c_wc, 1);
    cyc(1, 3'd1, 0);
    check("wrap_tick_drop", a_tick, 0);
    check("wrap_se", a_se, 0);
    check("wrap_st", a_st, 1);
    check("wrap_wc_hold", a_wc, 1);

    // ---------------- skip error 0,1,3 ----------------
    do_reset(1);
    cyc(1, 3'd0, 0);
    cyc(1, 3'd1, 0);
    cyc(1, 3'd3, 0);
    check("skip_se", a_se, 1);
    check("skip_ec", a_ec, 1);
    check("skip_st", a_st, 2);
    for (int v = 4; v <= 8; v++) begin
      cyc(1, 3'(v), 0);
      check("err_no_tick", a_tick, 0);
      check("err_ec_hold", a_ec, 1);
      check("err_se_hold", a_se, 1);
    end

    // ---------------- clear and resync ----------------
    cyc(1, 3'd5, 1);
    check("clr_se", a_se, 0);
    check("clr_st", a_st, 0);
    check("clr_ec_kept", a_ec, 1);
    cyc(1, 3'd6, 0);
    check("resync_st", a_st, 1);
    cyc(1, 3'd7, 0);
    check("resync_7_se", a_se, 0);
    check("resync_7_tick", a_tick, 0);
    cyc(1, 3'd0, 0);
    check("resync_tick", a_tick, 1);
    check("resync_wc", a_wc, 1);
    check("resync_se", a_se, 0);

    // ---------------- hold handling ----------------
    do_reset(1);
    cyc(1, 3'd2, 0);
    cyc(1, 3'd2, 0);
    check("hold0_se", a_se, 1);
    check("hold0_st", a_st, 2);
    check("hold1_se", b_se, 0);
    check("hold1_st", b_st, 1);
    cyc(1, 3'd3, 0);
    check("hold1_next_se", b_se, 0);
    check("hold1_next_ec", b_ec, 0);
    check("hold1_next_st", b_st, 1);

    do_reset(1);
    cyc(1, 3'd4, 0);
    cyc(0, 3'd7, 0);
    check("gap_tick", a_tick, 0);
    cyc(0, 3'd2, 0);
    cyc(1, 3'd5, 0);
    check("gap_a_se", a_se, 0);
    check("gap_b_se", b_se, 0);
    check("gap_a_st", a_st, 1);
    cyc(1, 3'd6, 0);
    check("gap_after_se", a_se, 0);

    // ---------------- saturation ----------------
    do_reset(1);
    cyc(1, 3'd0, 0);
    for (int w = 1; w <= 5; w++) begin
      for (int v = 1; v <= 7; v++) cyc(1, 3'(v), 0);
      cyc(1, 3'd0, 0);
      check("sat_tick", c_tick, 1);
      check("sat_wc", c_wc, (w >= 3) ? 3 : w);
      check("sat_ws", c_ws, (w >= 3) ? 1 : 0);
    end
    check("sat_a_wc", a_wc, 5);
    check("sat_a_ws", a_ws, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 3'd0, 0);
      cyc(1, 3'd5, 0);
      check("esat_se", c_se, 1);
      cyc(0, 3'd0, 1);
    end
    check("esat_c_ec", c_ec, 3);
    check("esat_a_ec", a_ec, 4);
    check("esat_c_wc_kept", c_wc, 3);

    // ---------------- reset mid-operation ----------------
    do_reset(1);
    cyc(1, 3'd0, 0);
    for (int w = 0; w < 2; w++) begin
      for (int v = 1; v <= 7; v++) cyc(1, 3'(v), 0);
      cyc(1, 3'd0, 0);
    end
    cyc(1, 3'd3, 0);
    check("mid_st_err", a_st, 2);
    check("mid_wc", a_wc, 2);
    reset = 1'b1; en = 1'b1; q_in = 3'd5; clear_err = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_tick", a_tick, 0);
    check("mid_rst_wc", a_wc, 0);
    check("mid_rst_ws", a_ws, 0);
    check("mid_rst_se", a_se, 0);
    check("mid_rst_ec", a_ec, 0);
    check("mid_rst_st", a_st, 0);
    cyc(1, 3'd4, 0);
    check("post_rst_st", a_st, 1);
    check("post_rst_se", a_se, 0);
    cyc(1, 3'd5, 0);
    check("post_rst_next_se", a_se, 0);
    check("post_rst_next_ec", a_ec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_count_seq_monitor
`default_nettype wire
